// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for a single 32-bit memory port
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_x, we_x, addr_x, wdata_x   requester A (fetch) and B (load/store) transaction inputs
//   gnt_x, done_x, err, rdata      grant, one-cycle completion pulse, timeout flag, read data
//   mux_sel, busy                  port mux select (1 = A), transaction in flight
//   mem_*                          memory port request/write side and ack/read-data return
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [31:0] addr_a,
  input  logic [31:0] wdata_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        done_a,
  output logic        done_b,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mux_sel,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Counter value seen during the last BUSY cycle allowed before abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               gnt_a_q, gnt_a_d;
  logic               gnt_b_q, gnt_b_d;
  logic               done_a_q, done_a_d;
  logic               done_b_q, done_b_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mux_sel_q, mux_sel_d;
  logic               last_a_q, last_a_d;   // 1 = A was served last
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timed_out;

  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    gnt_a_d   = gnt_a_q;
    gnt_b_d   = gnt_b_q;
    done_a_d  = 1'b0;
    done_b_d  = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    mux_sel_d = mux_sel_q;
    last_a_d  = last_a_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        // A wins when alone, or on a tie when B was served last.
        if (req_a && (!req_b || !last_a_q)) begin
          state_d   = BUSY;
          gnt_a_d   = 1'b1;
          mux_sel_d = 1'b1;
          cnt_d     = '0;
        end else if (req_b) begin
          state_d   = BUSY;
          gnt_b_d   = 1'b1;
          mux_sel_d = 1'b0;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        // An ack on the limit cycle still counts as a normal completion.
        if (mem_ack || timed_out) begin
          state_d  = IDLE;
          gnt_a_d  = 1'b0;
          gnt_b_d  = 1'b0;
          done_a_d = gnt_a_q;
          done_b_d = gnt_b_q;
          last_a_d = gnt_a_q;
          err_d    = !mem_ack;
          rdata_d  = mem_ack ? mem_rdata : 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      mux_sel_q <= 1'b0;
      last_a_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      mux_sel_q <= mux_sel_d;
      last_a_q  <= last_a_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mux_sel   = mux_sel_q;
  assign busy      = (state_q == BUSY);
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mux_sel_q ? we_a    : we_b;
  assign mem_addr  = mux_sel_q ? addr_a  : addr_b;
  assign mem_wdata = mux_sel_q ? wdata_a : wdata_b;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
  logic        gnt_a, gnt_b, done_a, done_b, err, mux_sel, busy, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_last_a = 1'b0;   // reference: 1 when A was the last requester served

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .err(err), .rdata(rdata), .mux_sel(mux_sel), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full transaction, entered and left at a negedge with the DUT idle.
  // delay = BUSY cycle (1-based) in which mem_ack is raised; delay > TO means no ack.
  task automatic do_txn(input bit ra, input bit rb, input bit wa, input bit wb,
                        input logic [31:0] aa, input logic [31:0] ab,
                        input logic [31:0] da, input logic [31:0] db,
                        input int delay, input logic [31:0] rd, input bit drop);
    bit          win_a;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [6:0]  vec;
    int          k;
    req_a = ra; req_b = rb; we_a = wa; we_b = wb;
    addr_a = aa; addr_b = ab; wdata_a = da; wdata_b = db;
    mem_ack = 1'b0;
    win_a = ra && (!rb || !exp_last_a);
    @(negedge clk);
    vec = {busy, gnt_a, gnt_b, mem_req, mux_sel, done_a, done_b};
    n_checks++;
    if (vec !== {1'b1, win_a, !win_a, 1'b1, win_a, 2'b00}) begin
      $display("FAIL grant: busy/gnt_a/gnt_b/mem_req/mux_sel/done_a/done_b got %b want %b",
               vec, {1'b1, win_a, !win_a, 1'b1, win_a, 2'b00});
      n_fail++;
    end
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== (win_a ? {wa, aa, da} : {wb, ab, db})) begin
      $display("FAIL port_mux: we/addr/wdata got %b/%h/%h want %b/%h/%h", mem_we, mem_addr,
               mem_wdata, win_a ? wa : wb, win_a ? aa : ab, win_a ? da : db);
      n_fail++;
    end
    if (drop) begin req_a = 1'b0; req_b = 1'b0; end
    k = 1;
    while (1) begin
      n_checks++;
      if ({busy, gnt_a, gnt_b} !== {1'b1, win_a, !win_a}) begin
        $display("FAIL busy_hold: cycle %0d busy/gnt_a/gnt_b got %b want %b", k,
                 {busy, gnt_a, gnt_b}, {1'b1, win_a, !win_a});
        n_fail++;
      end
      mem_ack = (k == delay);
      mem_rdata = (k == delay) ? rd : $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (k == delay || k == TO) break;
      k++;
    end
    exp_err = (delay > TO);
    exp_rd  = exp_err ? 32'h0 : rd;
    vec = {busy, gnt_a, gnt_b, mem_req, mux_sel, done_a, done_b};
    n_checks++;
    if (vec !== {4'b0000, win_a, win_a, !win_a}) begin
      $display("FAIL done: busy/gnt_a/gnt_b/mem_req/mux_sel/done_a/done_b got %b want %b",
               vec, {4'b0000, win_a, win_a, !win_a});
      n_fail++;
    end
    n_checks++;
    if ({err, rdata} !== {exp_err, exp_rd}) begin
      $display("FAIL result: err/rdata got %b/%h want %b/%h", err, rdata, exp_err, exp_rd);
      n_fail++;
    end
    exp_last_a = win_a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, gnt_a, gnt_b, done_a, done_b, err, mem_req, mux_sel, rdata} !== 40'h0) begin
      $display("FAIL reset: outputs got %b_%h want all zero",
               {busy, gnt_a, gnt_b, done_a, done_b, err, mem_req, mux_sel}, rdata);
      n_fail++;
    end
    exp_last_a = 1'b0;
  endtask

  task automatic test_single_read_a();
    do_txn(1, 0, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 3, 32'hDEAD_BEEF, 1);
  endtask

  task automatic test_write_b();
    do_txn(0, 1, 0, 1, $urandom, 32'h0000_0200, $urandom, 32'h1234_5678, 2, $urandom, 1);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++)
      do_txn(1, 1, 0, 0, 32'h100 + i, 32'h200 + i, $urandom, $urandom, 1, $urandom, 0);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_timeout();
    do_txn(1, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, TO + 2, $urandom, 1);
    do_txn(1, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, TO, 32'hCAFE_0004, 1);
  endtask

  task automatic test_reset_mid_busy();
    do_txn(1, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, 1, $urandom, 1);
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    n_checks++;
    if (gnt_b !== 1'b1) begin
      $display("FAIL pre_reset_gnt: gnt_b got %b want 1", gnt_b);
      n_fail++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_last_a = 1'b0;
    n_checks++;
    if ({busy, gnt_a, gnt_b, done_a, done_b, err, mem_req, mux_sel, rdata} !== 40'h0) begin
      $display("FAIL mid_reset: outputs got %b_%h want all zero",
               {busy, gnt_a, gnt_b, done_a, done_b, err, mem_req, mux_sel}, rdata);
      n_fail++;
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if ({busy, done_a, done_b} !== 3'b000) begin
      $display("FAIL late_ack: busy/done_a/done_b got %b want 000", {busy, done_a, done_b});
      n_fail++;
    end
    do_txn(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, 2, $urandom, 1);
  endtask

  task automatic test_spurious_ack();
    logic [31:0] held;
    held = rdata;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if ({busy, gnt_a, gnt_b, done_a, done_b, rdata} !== {5'b0, held}) begin
      $display("FAIL idle_ack: busy/gnt/done got %b rdata %h want 00000 rdata %h",
               {busy, gnt_a, gnt_b, done_a, done_b}, rdata, held);
      n_fail++;
    end
    do_txn(1, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, 3, $urandom, 1);
  endtask

  task automatic test_random();
    bit ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, 1);
      rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, $urandom,
             $urandom_range(1, TO + 2), $urandom, 1'($urandom_range(0, 1)));
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read_a();
    test_write_b();
    test_round_robin();
    test_timeout();
    test_reset_mid_busy();
    test_spurious_ack();
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
